// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//
// Quadrature front-end for an up/down position counter. Two asynchronous
// encoder phases (A/B) are synchronized, optionally glitch-filtered, and then
// decoded into a single-cycle step pulse plus a direction level.
//
// Build option:
//   QUAD_STEP_DECODER_FILTER_EN  defined   -> per-channel glitch filter built,
//                                             FILTER_LEN honoured, latency
//                                             FILTER_LEN+3 cycles.
//                                 undefined -> synchronized phases feed the
//                                             decoder directly, latency 3.
//
// Parameters:
//   FILTER_LEN  consecutive stable cycles before a phase change is accepted
//               (1..15, only meaningful with the filter built)
//
// Ports:
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   enable   in   1 = steps and error detection allowed; phase always tracks
//   a_in     in   encoder phase A (asynchronous)
//   b_in     in   encoder phase B (asynchronous)
//   err_clr  in   synchronous clear of the sticky error flag
//   step     out  one-cycle pulse per legal quadrature edge
//   up_down  out  direction of the latest step (1 = up, 0 = down)
//   err      out  sticky, set when both phases change in the same decode
//   phase    out  last accepted {A,B}
// -----------------------------------------------------------------------------
module quad_step_decoder #(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       err_clr,
    output logic       step,
    output logic       up_down,
    output logic       err,
    output logic [1:0] phase
);

    // The filter counters are 4 bits wide, so the hold length must fit.
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("quad_step_decoder: FILTER_LEN must be in 1..15");
    end

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        T_NONE,
        T_FWD,
        T_REV,
        T_DBL
    } trans_t;

    state_t     state;
    logic [1:0] init_cnt;
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] filt_val;
    trans_t     trans;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; anything flipping both
    // bits at once cannot come from a real encoder and is flagged.
    function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
        trans_t t;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: t = T_FWD;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: t = T_REV;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: t = T_DBL;
            default:                                t = T_NONE;
        endcase
        return t;
    endfunction

    // ---- stage p0/p1: two-flop synchronizer, {A,B} per bit ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 2'b00;
            sync_p1 <= 2'b00;
        end else begin
            sync_p0 <= {a_in, b_in};
            sync_p1 <= sync_p0;
        end
    end

`ifdef QUAD_STEP_DECODER_FILTER_EN
    localparam logic [3:0] FLEN = 4'(FILTER_LEN);

    logic [1:0] filt_q;
    logic [3:0] filt_cnt [2];

    // ---- stage p2: per-channel stability filter ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q      <= 2'b00;
            filt_cnt[0] <= 4'd0;
            filt_cnt[1] <= 4'd0;
        end else if (state == S_INIT) begin
            // Bypassed while priming so the first RUN compare starts from
            // whatever level the encoder is actually sitting at.
            filt_q      <= sync_p1;
            filt_cnt[0] <= 4'd0;
            filt_cnt[1] <= 4'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] != filt_q[i]) begin
                    // This cycle is the FILTER_LEN-th consecutive differing one.
                    if (filt_cnt[i] == FLEN - 4'd1) begin
                        filt_q[i]   <= sync_p1[i];
                        filt_cnt[i] <= 4'd0;
                    end else begin
                        filt_cnt[i] <= filt_cnt[i] + 4'd1;
                    end
                end else begin
                    filt_cnt[i] <= 4'd0;
                end
            end
        end
    end

    assign filt_val = (state == S_INIT) ? sync_p1 : filt_q;
`else
    assign filt_val = sync_p1;
`endif

    assign trans = classify(phase, filt_val);

    // ---- decode stage: priming FSM, step/direction and sticky error ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_INIT;
            init_cnt <= 2'd0;
            phase    <= 2'b00;
            step     <= 1'b0;
            up_down  <= 1'b1;
            err      <= 1'b0;
        end else begin
            step  <= 1'b0;
            phase <= filt_val;
            case (state)
                S_INIT: begin
                    // Three priming cycles let the synchronizer fill before
                    // any comparison can produce a step or an error.
                    if (init_cnt == 2'd2) begin
                        state <= S_RUN;
                    end else begin
                        init_cnt <= init_cnt + 2'd1;
                    end
                end
                S_RUN: begin
                    if (enable) begin
                        if (trans == T_FWD) begin
                            step    <= 1'b1;
                            up_down <= 1'b1;
                        end else if (trans == T_REV) begin
                            step    <= 1'b1;
                            up_down <= 1'b0;
                        end
                    end
                end
                default: state <= S_INIT;
            endcase

            // A new error wins over a clear requested in the same cycle.
            if (state == S_RUN && trans == T_DBL && enable) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
